// File: rtl/pipe_slice_pkg.sv
// Shared types and sizing helpers for the pipe_slice register chain.
package pipe_slice_pkg;

  typedef enum logic [1:0] {
    StEmpty,
    StBusy,
    StFull
  } stage_state_e;

  // Width of a counter that must represent 0..2*depth words.
  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(2 * depth + 1);
  endfunction

endpackage

// File: rtl/pipe_slice_stage.sv
// One skid-register stage of pipe_slice: main register plus skid register.
// Optional synchronous flush port when PIPE_SLICE_FLUSH_EN is defined.
module pipe_slice_stage
  import pipe_slice_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             aclk,
  input  logic             arstn,
`ifdef PIPE_SLICE_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  stage_state_e     state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             ready_q;
  logic             in_xfer, out_xfer;

  assign in_xfer   = in_valid & ready_q;
  assign out_xfer  = (state_q != StEmpty) & out_ready;
  assign in_ready  = ready_q;
  assign out_valid = (state_q != StEmpty);
  assign out_data  = main_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      StEmpty: begin
        if (in_xfer) begin
          state_d = StBusy;
          main_d  = in_data;
        end
      end
      StBusy: begin
        if (in_xfer && out_xfer) begin
          main_d = in_data;
        end else if (in_xfer) begin
          state_d = StFull;
          skid_d  = in_data;
        end else if (out_xfer) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        // ready_q is low here, so no input transfer can coincide.
        if (out_xfer) begin
          state_d = StBusy;
          main_d  = skid_q;
        end
      end
      default: state_d = StEmpty;
    endcase
`ifdef PIPE_SLICE_FLUSH_EN
    if (flush) begin
      state_d = StEmpty;
    end
`endif
  end

  always_ff @(posedge aclk) begin
    if (!arstn) begin
      state_q <= StEmpty;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= (state_d != StFull);
    end
  end

endmodule

// File: rtl/pipe_slice.sv
// DEPTH-stage valid/ready register slice with occupancy count.
// Define PIPE_SLICE_FLUSH_EN to add the synchronous flush port.
module pipe_slice
  import pipe_slice_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CntW = count_width(DEPTH)
) (
  input  logic             aclk,
  input  logic             arstn,
`ifdef PIPE_SLICE_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [CntW-1:0]  count
);

  localparam logic [CntW-1:0] MaxCount = CntW'(2 * DEPTH);

  // Index 0 is the upstream side, index DEPTH the downstream side.
  logic             vld [DEPTH+1];
  logic             rdy [DEPTH+1];
  logic [WIDTH-1:0] dat [DEPTH+1];

  assign vld[0]     = s_valid;
  assign dat[0]     = s_data;
  assign s_ready    = rdy[0];
  assign m_valid    = vld[DEPTH];
  assign m_data     = dat[DEPTH];
  assign rdy[DEPTH] = m_ready;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    pipe_slice_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .aclk     (aclk),
      .arstn    (arstn),
`ifdef PIPE_SLICE_FLUSH_EN
      .flush    (flush),
`endif
      .in_valid (vld[g]),
      .in_ready (rdy[g]),
      .in_data  (dat[g]),
      .out_valid(vld[g+1]),
      .out_ready(rdy[g+1]),
      .out_data (dat[g+1])
    );
  end

  logic            s_xfer, m_xfer;
  logic [CntW-1:0] count_q, count_d;

  assign s_xfer = s_valid & s_ready;
  assign m_xfer = m_valid & m_ready;
  assign count  = count_q;

  always_comb begin
    count_d = count_q;
    if (s_xfer && !m_xfer) begin
      count_d = count_q + CntW'(1);
    end else if (m_xfer && !s_xfer) begin
      count_d = count_q - CntW'(1);
    end
`ifdef PIPE_SLICE_FLUSH_EN
    if (flush) begin
      count_d = '0;
    end
`endif
  end

  always_ff @(posedge aclk) begin
    if (!arstn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  a_count_bound: assert property (@(posedge aclk) disable iff (!arstn) count_q <= MaxCount);
  a_hold_data: assert property (@(posedge aclk) disable iff (!arstn)
    (m_valid && !m_ready) |=> $stable(m_data));

endmodule

// File: doc/pipe_slice.md
PIPE_SLICE -- requirements
Module: pipe_slice

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 2, number of chained register stages (>=1).
REQ-003 aclk  input  1  clock; all state updates on rising edge.
REQ-004 arstn  input  1  reset, synchronous and active-low.
REQ-005 flush  input  1  synchronous discard of all held words (present only with PIPE_SLICE_FLUSH_EN).
REQ-006 s_valid  input  1  upstream word valid.
REQ-007 s_ready  output  1  upstream may transfer this cycle.
REQ-008 s_data  input  WIDTH  upstream word.
REQ-009 m_valid  output  1  downstream word valid.
REQ-010 m_ready  input  1  downstream accepts this cycle.
REQ-011 m_data  output  WIDTH  downstream word.
REQ-012 count  output  $clog2(2*DEPTH+1)  number of words currently held.

Function
REQ-013 A transfer SHALL occur on an edge where valid and ready are both 1 on the same interface.
REQ-014 Each stage SHALL be a skid register with states EMPTY, BUSY (main register holds a word) and FULL (main and skid registers hold a word).
REQ-015 Stage transitions SHALL be:
- EMPTY + input transfer -> BUSY.
- BUSY + input transfer only -> FULL (word into skid).
- BUSY + output transfer only -> EMPTY.
- BUSY + input and output transfers -> BUSY (main <= input).
- FULL + output transfer -> BUSY (main <= skid).
REQ-016 A stage's output valid SHALL be 1 when its state is not EMPTY, and its output data SHALL be the main register.
REQ-017 A stage's input ready SHALL be registered, equal to (next state != FULL).
REQ-018 A word SHALL appear on m_valid/m_data exactly DEPTH cycles after its s-side transfer when no backpressure exists.
REQ-019 Sustained throughput SHALL be one word per cycle with no bubbles while m_ready=1.
REQ-020 Total capacity SHALL be 2*DEPTH words; s_ready SHALL be 0 only when the first stage is FULL.
REQ-021 Words SHALL leave in acceptance order with no loss or duplication.
REQ-022 count SHALL be incremented on an s-transfer, decremented on an m-transfer, and unchanged when both occur on the same edge.
REQ-023 m_data SHALL hold stable while m_valid=1 and m_ready=0.

Reset
REQ-024 While arstn=0 at an edge, all stages SHALL go EMPTY, s_ready=0, m_valid=0, count=0, and m_data=0.
REQ-025 s_ready SHALL rise on the first edge with arstn=1; s_valid during reset SHALL be ignored.
REQ-026 Reset mid-stream SHALL discard all held words, overriding any simultaneous transfer.

Configuration
REQ-027 With PIPE_SLICE_FLUSH_EN defined, flush=1 at an edge SHALL set all stages EMPTY, count=0, m_valid=0 and s_ready=1 on the next cycle.
REQ-028 An s-transfer on a flush edge SHALL be discarded; an m-transfer on a flush edge SHALL count as delivered; flush SHALL rank below reset.
REQ-029 Without PIPE_SLICE_FLUSH_EN, the flush port and its logic SHALL be absent.

Structure
REQ-030 Package pipe_slice_pkg SHALL hold the stage state enum typedef and a count-width function.
REQ-031 One stage SHALL be sub-module pipe_slice_stage, instantiated DEPTH times in a generate chain.

Verification (WIDTH=8, DEPTH=2)
REQ-032 Reset: arstn=0 for 5 cycles with s_valid=1 -> m_valid=0, s_ready=0, count=0, m_data=0x00; s_ready=1 one edge after release.
REQ-033 Single word: 0xA5 sent with m_ready=1 -> m_valid=1 with m_data=0xA5 exactly 2 cycles later; count goes 1 then 0.
REQ-034 Streaming: 0x00..0x0F sent back-to-back with m_ready=1 -> same order on m_data, contiguous m_valid, s_ready constantly 1.
REQ-035 Backpressure: m_ready=0 while pushing -> exactly 4 words accepted, s_ready=0, count=4; then m_ready=1 -> 4 words drain in order, one per cycle.
REQ-036 Random m_ready (50%) and s_valid (50%) over 200 words -> scoreboard shows in-order delivery, no loss or duplicate.
REQ-037 Flush (macro defined): 3 words held, flush pulsed with s_valid=1 and s_data=0x33 -> next cycle m_valid=0, count=0; 0x33 is never delivered.
